// File: rtl/pq_pkg.sv
// Shared types and sizing for the priority queue and its request arbiter.
// The queue geometry constants are mirrored by the pq instance this arbiter fronts.
package pq_pkg;

   localparam int DATA_WIDTH  = 8;
   localparam int ID_WIDTH    = 4;
   localparam int QUEUE_DEPTH = 8;
   localparam int PQ_NREQ     = 4;

   typedef enum logic [1:0] {
      PQ_PUSH = 2'd0,
      PQ_POP  = 2'd1,
      PQ_DROP = 2'd2,
      PQ_ILL  = 2'd3
   } pq_op_e;

   typedef enum logic [2:0] {
      ARB_IDLE  = 3'd0,
      ARB_CHECK = 3'd1,
      ARB_ISSUE = 3'd2,
      ARB_CAPT  = 3'd3,
      ARB_RESP  = 3'd4
   } arb_state_e;

   // A command is refused up front when the queue cannot possibly serve it.
   function automatic logic op_rejected(input pq_op_e op, input logic full, input logic empty);
      logic rej;
      case (op)
         PQ_PUSH: rej = full;
         PQ_POP:  rej = empty;
         PQ_DROP: rej = 1'b0;
         default: rej = 1'b1;
      endcase
      return rej;
   endfunction

endpackage

// File: rtl/pq_arb_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant plus its index, with the
// requester at ptr having highest priority and priority ascending with wrap.
module rr_arb #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx
);

   logic          found_s;
   int            pos_s;
   logic [PW-1:0] idx_s;

   // Scan from the pointer upward and take the first active request.
   always_comb begin
      gnt     = {N{1'b0}};
      gnt_idx = {PW{1'b0}};
      found_s = 1'b0;
      pos_s   = 0;
      idx_s   = {PW{1'b0}};
      for (int i = 0; i < N; i++) begin
         pos_s = int'(ptr) + i;
         pos_s = (pos_s >= N) ? (pos_s - N) : pos_s;
         idx_s = PW'(pos_s);
         if (!found_s && req[idx_s]) begin
            found_s    = 1'b1;
            gnt[idx_s] = 1'b1;
            gnt_idx    = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/pq_arb.sv
// Round-robin front end that serializes PUSH/POP/DROP commands from NREQ
// requesters onto a single pq instance and routes each result back.
module pq_arb
   import pq_pkg::*;
#(
   parameter int NREQ = PQ_NREQ,
   parameter int DW   = DATA_WIDTH,
   parameter int IDW  = ID_WIDTH
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NREQ-1:0]   req_vld_i,
   input  logic [2*NREQ-1:0] req_op_i,
   input  logic [NREQ*DW-1:0]  req_data_i,
   input  logic [NREQ*IDW-1:0] req_id_i,
   output logic [NREQ-1:0]   req_rdy_o,
   output logic [NREQ-1:0]   rsp_vld_o,
   input  logic [NREQ-1:0]   rsp_rdy_i,
   output logic [DW-1:0]     rsp_data_o,
   output logic [IDW-1:0]    rsp_id_o,
   output logic              rsp_err_o,
   output logic              pq_push_o,
   output logic              pq_pop_o,
   output logic              pq_drop_o,
   output logic [DW-1:0]     pq_data_o,
   output logic [IDW-1:0]    pq_drop_id_o,
   input  logic              pq_push_rdy_i,
   input  logic              pq_pop_rdy_i,
   input  logic              pq_drop_rdy_i,
   input  logic [IDW-1:0]    pq_push_id_i,
   input  logic [DW-1:0]     pq_data_i,
   input  logic              pq_full_i,
   input  logic              pq_empty_i
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_e state_r, state_nx;

   logic [PW-1:0]   ptr_r, gnt_idx_r, gnt_idx_s, ptr_nx;
   logic [NREQ-1:0] gnt_s, gnt_onehot_s;
   pq_op_e          op_r;
   logic [1:0]      sel_op_s;
   logic [DW-1:0]   data_r, sel_data_s;
   logic [IDW-1:0]  id_r, sel_id_s, res_id_r;
   logic            hs_s, reject_s;

   logic            push_r, pop_r, drop_r;
   logic            push_nx, pop_nx, drop_nx;
   logic [DW-1:0]   pq_data_r, pq_data_nx;
   logic [IDW-1:0]  drop_id_r, drop_id_nx;
   logic [NREQ-1:0] rsp_vld_r, rsp_vld_nx;
   logic [DW-1:0]   rsp_data_r, rsp_data_nx;
   logic [IDW-1:0]  rsp_id_r, rsp_id_nx;
   logic            rsp_err_r, rsp_err_nx;

   rr_arb #(.N(NREQ), .PW(PW)) u_rr_arb (
      .req     (req_vld_i),
      .ptr     (ptr_r),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s)
   );

   // Gated by rst_ni so the accept pulse also drops the instant reset asserts.
   assign req_rdy_o = (rst_ni && (state_r == ARB_IDLE)) ? gnt_s : {NREQ{1'b0}};

   assign pq_push_o    = push_r;
   assign pq_pop_o     = pop_r;
   assign pq_drop_o    = drop_r;
   assign pq_data_o    = pq_data_r;
   assign pq_drop_id_o = drop_id_r;
   assign rsp_vld_o    = rsp_vld_r;
   assign rsp_data_o   = rsp_data_r;
   assign rsp_id_o     = rsp_id_r;
   assign rsp_err_o    = rsp_err_r;

   assign gnt_onehot_s = NREQ'(1'b1) << gnt_idx_r;
   assign reject_s     = op_rejected(op_r, pq_full_i, pq_empty_i);
   assign ptr_nx       = (gnt_idx_r == PW'(NREQ - 1)) ? {PW{1'b0}} : (gnt_idx_r + PW'(1'b1));

   // One-hot mux of the winning requester's command fields.
   always_comb begin
      sel_op_s   = 2'd0;
      sel_data_s = {DW{1'b0}};
      sel_id_s   = {IDW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         sel_op_s   = sel_op_s   | ({2{gnt_s[i]}}   & req_op_i[2*i +: 2]);
         sel_data_s = sel_data_s | ({DW{gnt_s[i]}}  & req_data_i[i*DW +: DW]);
         sel_id_s   = sel_id_s   | ({IDW{gnt_s[i]}} & req_id_i[i*IDW +: IDW]);
      end
   end

   // Queue-side ready for the command currently held.
   always_comb begin
      case (op_r)
         PQ_PUSH: hs_s = pq_push_rdy_i;
         PQ_POP:  hs_s = pq_pop_rdy_i;
         PQ_DROP: hs_s = pq_drop_rdy_i;
         default: hs_s = 1'b0;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         ARB_IDLE: begin
            if (|req_vld_i) state_nx = ARB_CHECK;
            else            state_nx = ARB_IDLE;
         end
         ARB_CHECK: begin
            if (reject_s) state_nx = ARB_RESP;
            else          state_nx = ARB_ISSUE;
         end
         ARB_ISSUE: begin
            if (hs_s) state_nx = ARB_CAPT;
            else      state_nx = ARB_ISSUE;
         end
         ARB_CAPT: state_nx = ARB_RESP;
         ARB_RESP: begin
            if (rsp_rdy_i[gnt_idx_r]) state_nx = ARB_IDLE;
            else                      state_nx = ARB_RESP;
         end
         default: state_nx = ARB_IDLE;
      endcase
   end

   // Output values for the coming cycle, derived from the state being entered.
   always_comb begin
      push_nx     = 1'b0;
      pop_nx      = 1'b0;
      drop_nx     = 1'b0;
      pq_data_nx  = {DW{1'b0}};
      drop_id_nx  = {IDW{1'b0}};
      rsp_vld_nx  = {NREQ{1'b0}};
      rsp_data_nx = {DW{1'b0}};
      rsp_id_nx   = {IDW{1'b0}};
      rsp_err_nx  = 1'b0;
      if (state_nx == ARB_ISSUE) begin
         push_nx    = (op_r == PQ_PUSH);
         pop_nx     = (op_r == PQ_POP);
         drop_nx    = (op_r == PQ_DROP);
         pq_data_nx = (op_r == PQ_PUSH) ? data_r : {DW{1'b0}};
         drop_id_nx = (op_r == PQ_DROP) ? id_r : {IDW{1'b0}};
      end else begin
         push_nx = 1'b0;
      end
      if (state_nx == ARB_RESP) begin
         rsp_vld_nx = gnt_onehot_s;
         if (state_r == ARB_RESP) begin
            rsp_data_nx = rsp_data_r;
            rsp_id_nx   = rsp_id_r;
            rsp_err_nx  = rsp_err_r;
         end else if (state_r == ARB_CHECK) begin
            rsp_err_nx = 1'b1;
         end else begin
            // Pop data arrives the cycle after the handshake, i.e. now in CAPT.
            rsp_data_nx = (op_r == PQ_POP) ? pq_data_i : {DW{1'b0}};
            rsp_id_nx   = res_id_r;
         end
      end else begin
         rsp_vld_nx = {NREQ{1'b0}};
      end
   end

   // State, pointer and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r    <= ARB_IDLE;
         ptr_r      <= {PW{1'b0}};
         push_r     <= 1'b0;
         pop_r      <= 1'b0;
         drop_r     <= 1'b0;
         pq_data_r  <= {DW{1'b0}};
         drop_id_r  <= {IDW{1'b0}};
         rsp_vld_r  <= {NREQ{1'b0}};
         rsp_data_r <= {DW{1'b0}};
         rsp_id_r   <= {IDW{1'b0}};
         rsp_err_r  <= 1'b0;
      end else begin
         state_r    <= state_nx;
         push_r     <= push_nx;
         pop_r      <= pop_nx;
         drop_r     <= drop_nx;
         pq_data_r  <= pq_data_nx;
         drop_id_r  <= drop_id_nx;
         rsp_vld_r  <= rsp_vld_nx;
         rsp_data_r <= rsp_data_nx;
         rsp_id_r   <= rsp_id_nx;
         rsp_err_r  <= rsp_err_nx;
         if ((state_r == ARB_RESP) && rsp_rdy_i[gnt_idx_r]) begin
            ptr_r <= ptr_nx;
         end
      end
   end

   // Command capture at accept and result ID capture at the queue handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gnt_idx_r <= {PW{1'b0}};
         op_r      <= PQ_PUSH;
         data_r    <= {DW{1'b0}};
         id_r      <= {IDW{1'b0}};
         res_id_r  <= {IDW{1'b0}};
      end else begin
         if ((state_r == ARB_IDLE) && (|req_vld_i)) begin
            gnt_idx_r <= gnt_idx_s;
            op_r      <= pq_op_e'(sel_op_s);
            data_r    <= sel_data_s;
            id_r      <= sel_id_s;
         end
         if ((state_r == ARB_ISSUE) && hs_s) begin
            if (op_r == PQ_PUSH)      res_id_r <= pq_push_id_i;
            else if (op_r == PQ_DROP) res_id_r <= id_r;
            else                      res_id_r <= {IDW{1'b0}};
         end
      end
   end

endmodule

// File: tb/tb_pq_arb.sv
// Directed bench for pq_arb with a behavioural min-first queue model behind it.
module tb_pq_arb;
   import pq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] vld = 4'h0;
   logic [1:0] op_a [4];
   logic [7:0] dat_a [4];
   logic [3:0] id_a [4];
   logic [3:0] rsp_rdy = 4'hF;
   logic       push_rdy = 1'b1, pop_rdy = 1'b1, drop_rdy = 1'b1;

   logic [3:0] req_rdy, rsp_vld;
   logic [7:0] rsp_data, pq_wdata, pq_rdata;
   logic [3:0] rsp_id, pq_drop_id, pq_push_id;
   logic       rsp_err, pq_push, pq_pop, pq_drop, pq_full, pq_empty;

   int checks = 0;
   int errors = 0;
   int strobe_cnt = 0;

   always #5 clk = ~clk;

   pq_arb dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_vld_i(vld),
      .req_op_i({op_a[3], op_a[2], op_a[1], op_a[0]}),
      .req_data_i({dat_a[3], dat_a[2], dat_a[1], dat_a[0]}),
      .req_id_i({id_a[3], id_a[2], id_a[1], id_a[0]}),
      .req_rdy_o(req_rdy), .rsp_vld_o(rsp_vld), .rsp_rdy_i(rsp_rdy),
      .rsp_data_o(rsp_data), .rsp_id_o(rsp_id), .rsp_err_o(rsp_err),
      .pq_push_o(pq_push), .pq_pop_o(pq_pop), .pq_drop_o(pq_drop),
      .pq_data_o(pq_wdata), .pq_drop_id_o(pq_drop_id),
      .pq_push_rdy_i(push_rdy), .pq_pop_rdy_i(pop_rdy), .pq_drop_rdy_i(drop_rdy),
      .pq_push_id_i(pq_push_id), .pq_data_i(pq_rdata),
      .pq_full_i(pq_full), .pq_empty_i(pq_empty)
   );

   // Queue model: smallest value pops first, ID = slot index.
   logic       q_v [QUEUE_DEPTH];
   logic [7:0] q_d [QUEUE_DEPTH];
   int         q_cnt;
   logic [3:0] free_idx, min_idx;
   logic       have_min, have_free;

   always_comb begin
      q_cnt = 0; free_idx = 4'd0; min_idx = 4'd0; have_min = 1'b0; have_free = 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         if (q_v[i]) begin
            q_cnt++;
            if (!have_min || (q_d[i] < q_d[min_idx])) begin
               min_idx = 4'(i); have_min = 1'b1;
            end
         end else if (!have_free) begin
            free_idx = 4'(i); have_free = 1'b1;
         end
      end
   end

   assign pq_full    = (q_cnt == QUEUE_DEPTH);
   assign pq_empty   = (q_cnt == 0);
   assign pq_push_id = free_idx;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            q_v[i] <= 1'b0; q_d[i] <= 8'h00;
         end
         pq_rdata <= 8'h00;
      end else begin
         if (pq_push && push_rdy) begin
            q_v[free_idx] <= 1'b1; q_d[free_idx] <= pq_wdata;
         end
         if (pq_pop && pop_rdy) begin
            q_v[min_idx] <= 1'b0; pq_rdata <= q_d[min_idx];
         end
         if (pq_drop && drop_rdy) q_v[pq_drop_id[2:0]] <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (pq_push || pq_pop || pq_drop) strobe_cnt <= strobe_cnt + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Issue one command from requester r and return the response seen by it.
   task automatic run_cmd(input int r, input logic [1:0] op, input logic [7:0] d,
                          input logic [3:0] id, output logic [7:0] rd,
                          output logic [3:0] rid, output logic rerr, output int lat);
      int n;
      @(negedge clk);
      vld[r] = 1'b1; op_a[r] = op; dat_a[r] = d; id_a[r] = id;
      n = 0;
      #1;
      while (!req_rdy[r] && n < 50) begin
         @(negedge clk); #1; n++;
      end
      chk("accept_timeout", {31'd0, req_rdy[r]}, 32'd1);
      @(negedge clk);
      vld[r] = 1'b0;
      lat = 1;
      while (!rsp_vld[r] && lat < 50) begin
         @(negedge clk); lat++;
      end
      rd = rsp_data; rid = rsp_id; rerr = rsp_err;
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      int         r;
      logic [1:0] op;
      logic [7:0] d;
      int         id_from;
      logic       e_err;
      logic [7:0] e_data;
      int         e_lat;
   } vec_t;

   vec_t       tv [14];
   logic [3:0] ids [14];

   initial begin
      logic [7:0] rd;
      logic [3:0] rid, sid;
      logic       rerr;
      int         lat, s0, ng, cyc, last, gidx;
      logic [31:0] snap;

      for (int i = 0; i < 4; i++) begin
         op_a[i] = 2'd0; dat_a[i] = 8'h00; id_a[i] = 4'h0;
      end
      tv[0]  = '{0, PQ_PUSH, 8'hF0, -1, 1'b0, 8'h00, 4};
      tv[1]  = '{1, PQ_PUSH, 8'h15, -1, 1'b0, 8'h00, 4};
      tv[2]  = '{2, PQ_PUSH, 8'h87, -1, 1'b0, 8'h00, 4};
      tv[3]  = '{3, PQ_POP,  8'h00, -1, 1'b0, 8'h15, 4};
      tv[4]  = '{3, PQ_POP,  8'h00, -1, 1'b0, 8'h87, 4};
      tv[5]  = '{3, PQ_POP,  8'h00, -1, 1'b0, 8'hF0, 4};
      tv[6]  = '{3, PQ_POP,  8'h00, -1, 1'b1, 8'h00, 2};
      tv[7]  = '{0, PQ_PUSH, 8'h01, -1, 1'b0, 8'h00, 4};
      tv[8]  = '{1, PQ_PUSH, 8'hEB, -1, 1'b0, 8'h00, 4};
      tv[9]  = '{2, PQ_PUSH, 8'hAF, -1, 1'b0, 8'h00, 4};
      tv[10] = '{3, PQ_DROP, 8'h00,  8, 1'b0, 8'h00, 4};
      tv[11] = '{0, PQ_POP,  8'h00, -1, 1'b0, 8'h01, 4};
      tv[12] = '{1, PQ_POP,  8'h00, -1, 1'b0, 8'hAF, 4};
      tv[13] = '{2, PQ_ILL,  8'h00, -1, 1'b1, 8'h00, 2};

      // Reset state
      #1;
      chk("rst_req_rdy", {28'd0, req_rdy}, 32'd0);
      chk("rst_rsp", {15'd0, rsp_vld, rsp_data, rsp_id, rsp_err}, 32'd0);
      chk("rst_pq", {13'd0, pq_push, pq_pop, pq_drop, pq_wdata, pq_drop_id}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Fairness: all four push continuously, also fills the queue
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         op_a[i] = PQ_PUSH; dat_a[i] = 8'h10 + 8'(i);
      end
      vld = 4'hF;
      ng = 0; cyc = 0; last = 0; gidx = 0;
      while (ng < 8 && cyc < 100) begin
         #1;
         if (req_rdy != 4'h0) begin
            for (int j = 0; j < 4; j++) if (req_rdy[j]) gidx = j;
            chk($sformatf("fair_grant%0d", ng), gidx, ng % 4);
            if (ng > 0) chk($sformatf("fair_gap%0d", ng), cyc - last, 5);
            last = cyc; ng++;
         end
         @(negedge clk); cyc++;
      end
      chk("fair_count", ng, 8);
      vld = 4'h0;
      repeat (6) @(negedge clk);

      // Full push is rejected without touching the queue
      s0 = strobe_cnt;
      run_cmd(0, PQ_PUSH, 8'hAA, 4'h0, rd, rid, rerr, lat);
      chk("full_err", {31'd0, rerr}, 32'd1);
      chk("full_lat", lat, 2);
      chk("full_nostrobe", strobe_cnt - s0, 0);

      do_reset();

      // Table-driven command vectors
      for (int k = 0; k < 14; k++) begin
         sid = (tv[k].id_from >= 0) ? ids[tv[k].id_from] : 4'h0;
         s0 = strobe_cnt;
         run_cmd(tv[k].r, tv[k].op, tv[k].d, sid, rd, rid, rerr, lat);
         ids[k] = rid;
         chk($sformatf("v%0d_err", k), {31'd0, rerr}, {31'd0, tv[k].e_err});
         chk($sformatf("v%0d_data", k), {24'd0, rd}, {24'd0, tv[k].e_data});
         chk($sformatf("v%0d_lat", k), lat, tv[k].e_lat);
         chk($sformatf("v%0d_strobes", k), strobe_cnt - s0, tv[k].e_err ? 0 : 1);
         if (tv[k].op == PQ_DROP) chk($sformatf("v%0d_id_echo", k), {28'd0, rid}, {28'd0, sid});
      end
      chk("push_ids_01", {31'd0, ids[0] != ids[1]}, 32'd1);
      chk("push_ids_02", {31'd0, ids[0] != ids[2]}, 32'd1);
      chk("push_ids_12", {31'd0, ids[1] != ids[2]}, 32'd1);

      // Response backpressure on requester 1
      rsp_rdy[1] = 1'b0;
      run_cmd(1, PQ_PUSH, 8'h55, 4'h0, rd, rid, rerr, lat);
      chk("bp_lat", lat, 4);
      snap = {15'd0, rsp_vld, rsp_data, rsp_id, rsp_err};
      chk("bp_vld", {28'd0, rsp_vld}, 32'd2);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("bp_stable%0d", c), {15'd0, rsp_vld, rsp_data, rsp_id, rsp_err}, snap);
      end
      rsp_rdy[1] = 1'b1;
      @(negedge clk);
      chk("bp_release", {28'd0, rsp_vld}, 32'd0);

      // Reset while stalled in ISSUE, then the pointer must be back at 0
      push_rdy = 1'b0;
      vld[2] = 1'b1; op_a[2] = PQ_PUSH; dat_a[2] = 8'h66;
      #1;
      chk("rr_ptr2_grant", {28'd0, req_rdy}, 32'd4);
      @(negedge clk); vld[2] = 1'b0;
      @(negedge clk);
      chk("issue_strobe", {31'd0, pq_push}, 32'd1);
      chk("issue_data", {24'd0, pq_wdata}, 32'h66);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", {28'd0, req_rdy}, 32'd0);
      chk("mid_rst_rsp", {15'd0, rsp_vld, rsp_data, rsp_id, rsp_err}, 32'd0);
      chk("mid_rst_pq", {13'd0, pq_push, pq_pop, pq_drop, pq_wdata, pq_drop_id}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; push_rdy = 1'b1;
      @(negedge clk);
      vld = 4'b1001; op_a[0] = PQ_PUSH; op_a[3] = PQ_PUSH;
      #1;
      chk("ptr_after_rst", {28'd0, req_rdy}, 32'd1);
      @(negedge clk); vld = 4'h0;
      repeat (6) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
